// File: rtl/id_decode_skid.sv
// Instruction-decode stage with a DEPTH-entry input FIFO and a registered output stage.
// Valid/ready on both sides; stall inserts bubbles and flush discards everything.
module id_decode_skid #(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 5,
   parameter int unsigned RF_SIZE     = 32,
   parameter int unsigned DEPTH       = 2,
   parameter logic [5:0]  J_OPCODE    = 6'h02,
   parameter logic [5:0]  JR_FUNCT    = 6'h08,
   parameter logic [5:0]  LUI_OPCODE  = 6'h0F,
   parameter logic [5:0]  ZEXT_OPCODE = 6'h0C
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   input  logic [PC_WIDTH-1:0]    in_pc,
   input  logic                   stall,
   input  logic                   flush,
   output logic [ADDR_WIDTH-1:0]  rf_rs,
   output logic [ADDR_WIDTH-1:0]  rf_rt,
   input  logic [DATA_WIDTH-1:0]  rf_data_rs,
   input  logic [DATA_WIDTH-1:0]  rf_data_rt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [5:0]             out_opcode,
   output logic [5:0]             out_funct,
   output logic [ADDR_WIDTH-1:0]  out_rs,
   output logic [ADDR_WIDTH-1:0]  out_rt,
   output logic [ADDR_WIDTH-1:0]  out_rd,
   output logic [DATA_WIDTH-1:0]  out_imm,
   output logic [DATA_WIDTH-1:0]  out_data_rs,
   output logic [DATA_WIDTH-1:0]  out_data_rt,
   output logic [PC_WIDTH-1:0]    out_next_pc,
   output logic                   jump_valid,
   output logic [PC_WIDTH-1:0]    jump_addr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [INSTR_WIDTH-1:0] fifo_instr_q [DEPTH];
   logic [PC_WIDTH-1:0]    fifo_pc_q    [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q;

   logic                   out_valid_q;
   logic [5:0]             opcode_q, funct_q;
   logic [ADDR_WIDTH-1:0]  rs_q, rt_q, rd_q;
   logic [DATA_WIDTH-1:0]  imm_q, data_rs_q, data_rt_q;
   logic [PC_WIDTH-1:0]    next_pc_q;
   logic [25:0]            target_q;

   logic                   empty, full, push, pop, load;
   logic [INSTR_WIDTH-1:0] head_instr;
   logic [PC_WIDTH-1:0]    head_pc;
   logic                   is_j, is_jr;

   function automatic logic [ADDR_WIDTH-1:0] clamp_addr(input logic [4:0] field);
      if (32'(field) >= RF_SIZE) return ADDR_WIDTH'(RF_SIZE - 1);
      return ADDR_WIDTH'(field);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] ext_imm(input logic [5:0] op,
                                                     input logic [15:0] imm);
      if (op == LUI_OPCODE) return DATA_WIDTH'({imm, 16'h0000});
      if (op == ZEXT_OPCODE) return DATA_WIDTH'(imm);
      return DATA_WIDTH'($signed(imm));
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) return '0;
      return ptr + PTR_W'(1);
   endfunction

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   // rst gates in_ready so nothing is accepted while reset is held
   assign in_ready   = rst & ~full;
   assign push       = in_valid & in_ready & ~flush;
   assign load       = ~out_valid_q | out_ready;
   assign pop        = load & ~empty & ~stall & ~flush;
   assign head_instr = fifo_instr_q[rd_ptr_q];
   assign head_pc    = fifo_pc_q[rd_ptr_q];

   assign rf_rs = empty ? '0 : clamp_addr(head_instr[25:21]);
   assign rf_rt = empty ? '0 : clamp_addr(head_instr[20:16]);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= in_instr;
         fifo_pc_q[wr_ptr_q]    <= in_pc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Bubbles clear only out_valid; the data fields keep their last values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         funct_q     <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         data_rs_q   <= '0;
         data_rt_q   <= '0;
         next_pc_q   <= '0;
         target_q    <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (load) begin
         out_valid_q <= pop;
         if (pop) begin
            opcode_q  <= head_instr[31:26];
            funct_q   <= head_instr[5:0];
            rs_q      <= ADDR_WIDTH'(head_instr[25:21]);
            rt_q      <= ADDR_WIDTH'(head_instr[20:16]);
            rd_q      <= ADDR_WIDTH'(head_instr[15:11]);
            imm_q     <= ext_imm(head_instr[31:26], head_instr[15:0]);
            data_rs_q <= rf_data_rs;
            data_rt_q <= rf_data_rt;
            next_pc_q <= head_pc + PC_WIDTH'(1);
            target_q  <= head_instr[25:0];
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_opcode  = opcode_q;
   assign out_funct   = funct_q;
   assign out_rs      = rs_q;
   assign out_rt      = rt_q;
   assign out_rd      = rd_q;
   assign out_imm     = imm_q;
   assign out_data_rs = data_rs_q;
   assign out_data_rt = data_rt_q;
   assign out_next_pc = next_pc_q;

   assign is_j       = (opcode_q == J_OPCODE);
   assign is_jr      = (opcode_q == 6'h00) && (funct_q == JR_FUNCT);
   assign jump_addr  = is_j ? PC_WIDTH'(target_q) : PC_WIDTH'(data_rs_q);
   assign jump_valid = out_valid_q & out_ready & (is_j | is_jr);

endmodule
